aes_cipher_iter: RTL and testbench
==================================

Name: aes_cipher_iter

Overview:
- Iterative AES encryption engine. Sits directly downstream of the key expander and consumes its round-key array `k_sch[0:Nr]`.
- Applies one cipher round per clock to a single 128-bit block.
- Valid/ready handshakes on input and output.
- One block in flight at a time. AES-128/192/256 selected by `Nk`, which must match the expander instance.

Parameters:
- `Nk`, default 4: key length in 32-bit words (4/6/8); must equal the expander's `Nk`.
- `Nr`, default `Nk+6`: number of rounds; sets round-counter range and `k_sch` depth.

Ports:
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  `in_data` holds a plaintext block.
- `in_ready`  output  1  engine can accept a block this cycle.
- `in_data`  input  128  plaintext; word w = `[32w+:32]`, byte b of word w = `[32w+8b+:8]` = FIPS byte index 4w+b.
- `k_sch`  input  128 x (`Nr`+1)  round keys from the expander, same word/byte layout.
- `out_valid`  output  1  `out_data` holds a finished ciphertext.
- `out_ready`  input  1  consumer accepts `out_data` this cycle.
- `out_data`  output  128  ciphertext, same layout as `in_data`.

Behaviour:
- **Reset** (`rst`=1 at an edge; overrides everything):
  - FSM goes to IDLE, `round` goes to 0, state register goes to 0.
  - `out_valid`=0, `out_data`=0.
  - `in_ready`=1 from the first cycle after reset.
  - Reset mid-operation discards the block in flight with no output.
- **FSM states:** IDLE, RUN, DONE.
- **`in_ready`** = (FSM==IDLE), decoded from registered state only, with no combinational path from `in_valid` or `out_ready`.
- **IDLE:**
  - On `in_valid` && `in_ready` at edge T0: state <= `in_data` ^ `k_sch[0]`, `round` <= 1, go to RUN.
  - Otherwise hold.
- **RUN:**
  - Each edge with `round` = r in 1..Nr-1: state <= MixColumns(ShiftRows(SubBytes(state))) ^ `k_sch[r]`; `round` <= r+1.
  - At `round` = Nr: state <= ShiftRows(SubBytes(state)) ^ `k_sch[Nr]`, with no MixColumns. Go to DONE and set `out_valid`=1.
- **Latency:** `out_valid` rises exactly Nr cycles after the accept edge T0: 10, 12 or 14 for Nk=4/6/8.
- **DONE:**
  - `out_data` = state register, held stable; `out_valid` held while `out_ready`=0 (backpressure of any length).
  - On `out_valid` && `out_ready`: `out_valid` <= 0, go to IDLE.
  - No accept in DONE. Minimum spacing between accepts is Nr+2 cycles.
- **Key stability:** `k_sch` is sampled every RUN cycle; the upstream must hold the key stable from the accept edge until `out_valid`. The engine does not latch the key.
- **Round counter:** width `$clog2(Nr+1)`; never exceeds Nr and does not wrap.
- **X-safety:** `in_valid` ignored outside IDLE; `out_ready` ignored outside DONE.
- **Arithmetic:** GF(2^8) with polynomial 0x11B. xtime(a) = (a<<1) ^ (a[7] ? 0x1B : 0), truncated to 8 bits.
- **ShiftRows:** row b of the output, column c, takes row b, column (c+b) mod 4 of the input.

Decomposition:
- **Shared package (the existing AES include):** SBOX constant, SubBytes/ShiftRows/MixColumns/xtime functions, and an FSM state enum.
  - Bytewise functions operating on the 128-bit layout above; SubWord is shared with the expander.
- **Sub-module `aes_round`:** combinational; inputs state, round key and `final_round` flag; output next state. The engine instantiates it once and muxes `k_sch[round]`.

Test Plan:
- **FIPS-197 App. B, Nk=4:**
  - Stimulus: key bytes 2b7e1516 28aed2a6 abf71588 09cf4f3c through the expander; plaintext 3243f6a8 885a308d 313198a2 e0370734.
  - Response: `out_data` bytes 3925841d 02dc09fb dc118597 196a0b32, `out_valid` exactly 10 cycles after accept.
- **FIPS-197 C.1, Nk=4:**
  - Stimulus: key 000102..0f; plaintext 00112233445566778899aabbccddeeff.
  - Response: 69c4e0d86a7b0430d8cdb78070b4c55a.
- **FIPS-197 C.3, Nk=8:**
  - Stimulus: key 00..1f; same plaintext.
  - Response: 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
- **Backpressure:**
  - Stimulus: hold `out_ready`=0 for 20 cycles after `out_valid`.
  - Response: `out_data` and `out_valid` stable; `in_ready`=0 throughout; `in_valid` pulses ignored. Release gives exactly one transfer and `in_ready`=1 on the next cycle.
- **Back-to-back:**
  - Stimulus: `in_valid` held high with two blocks, `out_ready` tied to 1.
  - Response: second accept occurs Nr+2 cycles after the first; both ciphertexts match C.1.
- **Reset mid-operation:**
  - Stimulus: assert `rst` for 1 cycle at round 5.
  - Response: next cycle `out_valid`=0, `out_data`=0, `in_ready`=1; a new C.1 block then completes correctly.

Source files
------------

// File: rtl/aes_cipher_iter_pkg.sv
// Shared AES helpers: S-box, bytewise round transforms on the 128-bit layout
// (byte 4w+b at [32w+8b +: 8]), and the cipher engine FSM encoding.
package aes_cipher_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = SBOX[w[8*b +: 8]];
        end
        return r;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int w = 0; w < 4; w++) begin
            r[32*w +: 32] = sub_word(s[32*w +: 32]);
        end
        return r;
    endfunction

    // Row r of column c is fed from row r of column (c+r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            for (int b = 0; b < 4; b++) begin
                r[32*c + 8*b +: 8] = s[32*((c + b) % 4) + 8*b +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[7:0];
        a1 = col[15:8];
        a2 = col[23:16];
        a3 = col[31:24];
        return {xtime(a3) ^ xtime(a0) ^ a0 ^ a1 ^ a2,
                xtime(a2) ^ xtime(a3) ^ a3 ^ a0 ^ a1,
                xtime(a1) ^ xtime(a2) ^ a2 ^ a3 ^ a0,
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            r[32*c +: 32] = mix_column(s[32*c +: 32]);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One AES encryption round, purely combinational.
// The final round skips MixColumns.
module aes_round
    import aes_cipher_iter_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rkey,
    input  logic         final_round,
    output logic [127:0] nxt
);

    logic [127:0] shifted;

    assign shifted = shift_rows(sub_bytes(state));
    assign nxt     = (final_round ? shifted : mix_columns(shifted)) ^ rkey;

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryptor: one round per clock, out_valid rises Nr cycles after accept.
// Ciphertext is held in DONE for any length of backpressure; nothing is accepted until it drains.
module aes_cipher_iter
    import aes_cipher_iter_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] k_sch [0:Nr],
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int            RW   = $clog2(Nr + 1);
    localparam logic [RW-1:0] LAST = RW'(Nr);

    fsm_e          fsm_q, fsm_d;
    logic [RW-1:0] round_q, round_d;
    logic [127:0]  state_q, state_d;
    logic          out_valid_q, out_valid_d;
    logic [127:0]  rkey;
    logic [127:0]  round_out;
    logic          final_round;

    // The key array is not latched: the round key is looked up live every RUN cycle.
    assign rkey        = k_sch[round_q];
    assign final_round = (round_q == LAST);

    aes_round u_round (
        .state       (state_q),
        .rkey        (rkey),
        .final_round (final_round),
        .nxt         (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            round_q     <= '0;
            state_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            round_q     <= round_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        round_d     = round_q;
        state_d     = state_q;
        out_valid_d = out_valid_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = in_data ^ k_sch[0];
                    round_d = RW'(1);
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                state_d = round_out;
                if (final_round) begin
                    fsm_d       = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    round_d = round_q + RW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    round_d     = '0;
                    fsm_d       = IDLE;
                end
            end
            default: begin
                fsm_d       = IDLE;
                round_d     = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Ready comes only from registered state, so no in_valid/out_ready combinational path.
    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = state_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Checks AES-128/192/256 engines against FIPS-197 vectors and a byte-level model
// built from GF(2^8) arithmetic, including latency, backpressure, back-to-back and reset.
module tb_aes_cipher_iter;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic         out_ready;
    logic [1:0]   sel;

    logic         iv4, ir4, ov4, iv6, ir6, ov6, iv8, ir8, ov8;
    logic [127:0] od4, od6, od8;
    logic [127:0] k4 [0:10];
    logic [127:0] k6 [0:12];
    logic [127:0] k8 [0:14];

    logic         cur_ready, cur_ov;
    logic [127:0] cur_od;

    int checks   = 0;
    int failures = 0;

    bit [7:0] sb   [256];
    bit [7:0] keyb [32];
    bit [7:0] w    [60][4];

    assign iv4 = in_valid && (sel == 2'd0);
    assign iv6 = in_valid && (sel == 2'd1);
    assign iv8 = in_valid && (sel == 2'd2);
    assign cur_ready = (sel == 2'd0) ? ir4 : (sel == 2'd1) ? ir6 : ir8;
    assign cur_ov    = (sel == 2'd0) ? ov4 : (sel == 2'd1) ? ov6 : ov8;
    assign cur_od    = (sel == 2'd0) ? od4 : (sel == 2'd1) ? od6 : od8;

    aes_cipher_iter #(.Nk(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_data(in_data),
        .k_sch(k4), .out_valid(ov4), .out_ready(out_ready), .out_data(od4)
    );
    aes_cipher_iter #(.Nk(6)) u_dut6 (
        .clk(clk), .rst(rst), .in_valid(iv6), .in_ready(ir6), .in_data(in_data),
        .k_sch(k6), .out_valid(ov6), .out_ready(out_ready), .out_data(od6)
    );
    aes_cipher_iter #(.Nk(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_data(in_data),
        .k_sch(k8), .out_valid(ov8), .out_ready(out_ready), .out_data(od8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Polynomial multiply then long division by 0x11B.
    function automatic bit [7:0] gmul(input bit [7:0] a, input bit [7:0] b);
        bit [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic bit [7:0] rotl8(input bit [7:0] x, input int n);
        bit [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        bit [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // FIPS byte strings are written MSB-first; the port puts byte 0 in bits [7:0].
    function automatic logic [127:0] f2l(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
        return y;
    endfunction

    task automatic set_key(input logic [255:0] k);
        for (int i = 0; i < 32; i++) keyb[i] = k[8*(31-i) +: 8];
    endtask

    task automatic expand(input int nk);
        int       nr;
        bit [7:0] t [4];
        bit [7:0] tmp;
        bit [7:0] rc;
        logic [127:0] rk;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) for (int j = 0; j < 4; j++) w[i][j] = keyb[4*i + j];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
            if (i % nk == 0) begin
                tmp  = t[0];
                t[0] = sb[t[1]] ^ rc;
                t[1] = sb[t[2]];
                t[2] = sb[t[3]];
                t[3] = sb[tmp];
                rc   = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                for (int j = 0; j < 4; j++) t[j] = sb[t[j]];
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-nk][j] ^ t[j];
        end
        for (int r = 0; r <= nr; r++) begin
            for (int c = 0; c < 4; c++) for (int j = 0; j < 4; j++) rk[8*(4*c + j) +: 8] = w[4*r + c][j];
            if (nk == 4) k4[r] = rk;
            else if (nk == 6) k6[r] = rk;
            else k8[r] = rk;
        end
    endtask

    task automatic ref_cipher(input logic [127:0] pt, input int nr, output logic [127:0] ct);
        bit [7:0] s [16];
        bit [7:0] t [16];
        bit [7:0] a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ w[i/4][i%4];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++) for (int b = 0; b < 4; b++) s[4*c + b] = t[4*((c + b) % 4) + b];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][i%4];
        end
        for (int i = 0; i < 16; i++) ct[8*i +: 8] = s[i];
    endtask

    // Entered and left at a negedge. Checks latency, ciphertext, hold under bp, and drain.
    task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] exp, input int bp);
        int nr;
        int lat;
        int wt;
        nr = (sel == 2'd0) ? 10 : (sel == 2'd1) ? 12 : 14;
        wt = 0;
        while (!cur_ready && wt < 50) begin @(negedge clk); wt++; end
        in_data   = pt;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!cur_ov && lat < 40) begin @(negedge clk); lat++; end
        check({tag, "_lat"}, 136'(lat), 136'(nr));
        check({tag, "_ct"}, 136'(cur_od), 136'(exp));
        repeat (bp) @(negedge clk);
        check({tag, "_hold"}, 136'({cur_ov, cur_od}), 136'({1'b1, exp}));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drain"}, 136'({cur_ov, cur_ready}), 136'({1'b0, 1'b1}));
    endtask

    logic [127:0] c1_pt, c1_ct, pt, exp_ct;
    int           lat, acc, outs, nk_r;
    int           acc_t [2];

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; sel = 2'd0;
        build_sbox();
        c1_pt = f2l(128'h00112233445566778899aabbccddeeff);
        c1_ct = f2l(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_ready4", 136'(ir4), 136'(1'b1));
        check("rst_valid4", 136'(ov4), 136'(1'b0));
        check("rst_data4",  136'(od4), 136'(0));
        check("rst_state8", 136'({ir8, ov8, od8}), 136'({1'b1, 1'b0, 128'h0}));

        sel = 2'd0;
        set_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        expand(4);
        run_block("appB", f2l(128'h3243f6a8885a308d313198a2e0370734),
                  f2l(128'h3925841d02dc09fbdc118597196a0b32), 0);

        set_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        expand(4);
        run_block("c1", c1_pt, c1_ct, 1);

        sel = 2'd1;
        set_key({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
        expand(6);
        run_block("c2", c1_pt, f2l(128'hdda97ca4864cdfe06eaf70a0ec0d7191), 0);

        sel = 2'd2;
        set_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        expand(8);
        run_block("c3", c1_pt, f2l(128'h8ea2b7ca516745bfeafc49904b496089), 2);

        // Backpressure: 20 stalled cycles with in_valid pulses that must be ignored.
        sel = 2'd0;
        set_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        expand(4);
        in_data = c1_pt; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!cur_ov && lat < 40) begin @(negedge clk); lat++; end
        check("bp_lat", 136'(lat), 136'(10));
        for (int k = 0; k < 20; k++) begin
            in_valid = k[0];
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check($sformatf("bp_stall%0d", k), 136'({cur_ov, cur_ready, cur_od}), 136'({1'b1, 1'b0, c1_ct}));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 136'({cur_ov, cur_ready}), 136'({1'b0, 1'b1}));
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_single", 136'({cur_ov, cur_ready}), 136'({1'b0, 1'b1}));

        // Back-to-back with in_valid held high and out_ready tied high.
        in_data = c1_pt; in_valid = 1'b1; out_ready = 1'b1;
        acc = 0; outs = 0;
        for (int cyc = 0; cyc < 60 && outs < 2; cyc++) begin
            if (acc == 2) in_valid = 1'b0;
            if (in_valid && cur_ready && acc < 2) begin acc_t[acc] = cyc; acc++; end
            if (cur_ov) begin
                check($sformatf("b2b_ct%0d", outs), 136'(cur_od), 136'(c1_ct));
                outs++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_outs", 136'(outs), 136'(2));
        check("b2b_spacing", 136'(acc_t[1] - acc_t[0]), 136'(12));

        // Reset while round 5 is in the state register.
        @(negedge clk);
        in_data = c1_pt; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", 136'({cur_ov, cur_ready}), 136'({1'b0, 1'b0}));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst", 136'({cur_ov, cur_ready, cur_od}), 136'({1'b0, 1'b1, 128'h0}));
        run_block("mid_after", c1_pt, c1_ct, 0);

        // Random keys, key sizes and plaintexts against the byte-level model.
        for (int i = 0; i < 6; i++) begin
            nk_r = 4 + 2 * int'($urandom_range(0, 2));
            sel  = 2'((nk_r - 4) / 2);
            for (int j = 0; j < 32; j++) keyb[j] = 8'($urandom);
            expand(nk_r);
            pt = {$urandom, $urandom, $urandom, $urandom};
            ref_cipher(pt, nk_r + 6, exp_ct);
            run_block($sformatf("rnd%0d_nk%0d", i, nk_r), pt, exp_ct, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
